// File: rtl/fp_mul_pipe.sv
`default_nettype none
// ============================================================================
// fp_mul_pipe : three-stage pipelined floating-point multiplier with
//               valid/ready handshakes, RNE or truncation, flush-to-zero.
// Revision    : 1.0  initial release
// ============================================================================
module fp_mul_pipe #(
  parameter int EXP_W    = 8,
  parameter int MAN_W    = 23,
  parameter int ROUND_EN = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   res,
  output logic                   flag_ovf,
  output logic                   flag_unf,
  output logic                   flag_inv
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int PW = 2*MAN_W + 2;
  localparam int EW = EXP_W + 2;
  localparam logic [EW-1:0]        BIAS   = {3'b000, {(EXP_W-1){1'b1}}};
  localparam logic signed [EW:0]   E_ONE  = {{EW{1'b0}}, 1'b1};
  localparam logic signed [EW:0]   E_TOP  = {3'b000, {EXP_W{1'b1}}};
  localparam logic signed [EW:0]   E_ZERO = '0;

  logic advance;
  assign advance  = !(out_valid && !out_ready);
  assign in_ready = rst_n && advance;

  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;
  logic a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;
  assign {ea, fa} = a[W-2:0];
  assign {eb, fb} = b[W-2:0];
  assign a_zero = (ea == '0);
  assign b_zero = (eb == '0);
  assign a_inf  = (&ea) && (fa == '0);
  assign b_inf  = (&eb) && (fb == '0);
  assign a_nan  = (&ea) && (fa != '0);
  assign b_nan  = (&eb) && (fb != '0);

  logic                 s1_valid, s1_sign, s1_nan, s1_inf, s1_zero;
  logic signed [EW-1:0] s1_exp;
  logic [MAN_W:0]       s1_ma, s1_mb;
  logic                 s2_valid, s2_sign, s2_nan, s2_inf, s2_zero;
  logic signed [EW-1:0] s2_exp;
  logic [PW-1:0]        s2_prod;

  // Stage 3 combinational normalise / round / pack
  logic [MAN_W-1:0]   nfrac;
  logic               guard, sticky, rnd;
  logic signed [EW:0] nexp, rexp;
  logic [MAN_W:0]     rfrac;
  logic [W-1:0]       pack;
  logic               p_inv, p_ovf, p_unf;

  always_comb begin
    if (s2_prod[PW-1]) begin
      nfrac  = s2_prod[PW-2:MAN_W+1];
      guard  = s2_prod[MAN_W];
      sticky = |s2_prod[MAN_W-1:0];
      nexp   = $signed({s2_exp[EW-1], s2_exp}) + E_ONE;
    end else begin
      nfrac  = s2_prod[PW-3:MAN_W];
      guard  = s2_prod[MAN_W-1];
      sticky = |s2_prod[MAN_W-2:0];
      nexp   = $signed({s2_exp[EW-1], s2_exp});
    end
    rnd   = (ROUND_EN != 0) && guard && (sticky || nfrac[0]);
    rfrac = {1'b0, nfrac} + {{MAN_W{1'b0}}, rnd};
    // A rounding carry leaves rfrac[MAN_W-1:0] all zero, so only e moves.
    rexp  = nexp + $signed({{EW{1'b0}}, rfrac[MAN_W]});
    pack  = {s2_sign, rexp[EXP_W-1:0], rfrac[MAN_W-1:0]};
    p_inv = 1'b0;
    p_ovf = 1'b0;
    p_unf = 1'b0;
    if (s2_nan) begin
      pack  = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
      p_inv = 1'b1;
    end else if (s2_inf) begin
      pack = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (s2_zero) begin
      pack = {s2_sign, {(W-1){1'b0}}};
    end else if (rexp >= E_TOP) begin
      pack  = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      p_ovf = 1'b1;
    end else if (rexp <= E_ZERO) begin
      pack  = {s2_sign, {(W-1){1'b0}}};
      p_unf = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      out_valid <= 1'b0;
      res       <= '0;
      flag_ovf  <= 1'b0;
      flag_unf  <= 1'b0;
      flag_inv  <= 1'b0;
    end else if (advance) begin
      s1_valid  <= in_valid;
      s1_sign   <= a[W-1] ^ b[W-1];
      s1_exp    <= {2'b00, ea} + {2'b00, eb} - BIAS;
      s1_ma     <= {1'b1, fa};
      s1_mb     <= {1'b1, fb};
      s1_nan    <= a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero);
      s1_inf    <= a_inf | b_inf;
      s1_zero   <= a_zero | b_zero;

      s2_valid  <= s1_valid;
      s2_sign   <= s1_sign;
      s2_exp    <= s1_exp;
      s2_prod   <= {{(MAN_W+1){1'b0}}, s1_ma} * {{(MAN_W+1){1'b0}}, s1_mb};
      s2_nan    <= s1_nan;
      s2_inf    <= s1_inf;
      s2_zero   <= s1_zero;

      out_valid <= s2_valid;
      res       <= pack;
      flag_inv  <= s2_valid && p_inv;
      flag_ovf  <= s2_valid && p_ovf;
      flag_unf  <= s2_valid && p_unf;
    end
  end

endmodule
`default_nettype wire
